// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neuron_pkg
// Purpose  : Shared constants and types for the time-multiplexed neuron
//            scheduler: default array geometry, FSM state encoding and the
//            configuration values loaded at reset.
// Revision : 1.0  initial release
// ============================================================================
package neuron_pkg;

  localparam int NUM_NEURONS  = 8;   // virtual neurons per sweep
  localparam int STATE_W      = 6;   // membrane / current / threshold width
  localparam int IDX_W        = 3;   // neuron index width on the ports
  localparam int THR_DEFAULT  = 32;  // threshold after reset
  localparam int LEAK_DEFAULT = 1;   // leak shift after reset

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_DONE   = 2'd2
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/neuron_update.sv
`default_nettype none
// ============================================================================
// Module   : neuron_update
// Purpose  : Combinational per-neuron update: leak, saturating add and
//            threshold compare. One instance is shared by all neurons.
// Ports    : i_state      current membrane state
//            i_cur        input current consumed this update
//            i_spike_prev spike flag from the previous sweep (refractory)
//            i_leak       leak shift amount 0..3
//            i_thr        firing threshold
//            o_state      new (saturated) membrane state
//            o_spike      new spike flag
// Revision : 1.0  initial release
// ============================================================================
module neuron_update #(
  parameter int STATE_W = neuron_pkg::STATE_W
) (
  input  logic [STATE_W-1:0] i_state,
  input  logic [STATE_W-1:0] i_cur,
  input  logic               i_spike_prev,
  input  logic [1:0]         i_leak,
  input  logic [STATE_W-1:0] i_thr,
  output logic [STATE_W-1:0] o_state,
  output logic               o_spike
);

  logic [STATE_W-1:0] w_leak_term;
  logic [STATE_W:0]   w_sum;

  // A neuron that fired last sweep contributes no retained potential.
  assign w_leak_term = i_spike_prev ? '0 : (i_state >> i_leak);

  // One extra bit catches overflow so the result can clamp to all-ones.
  assign w_sum   = {1'b0, i_cur} + {1'b0, w_leak_term};
  assign o_state = w_sum[STATE_W] ? {STATE_W{1'b1}} : w_sum[STATE_W-1:0];
  assign o_spike = (o_state >= i_thr);

endmodule
`default_nettype wire

// File: rtl/neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : neuron_scheduler
// Purpose  : Sweeps NUM_NEURONS virtual neurons through one shared update
//            datapath, one neuron per cycle, on each step pulse.
// Ports    : clk, reset        clock, synchronous active-high reset
//            i_step            starts a sweep (ignored unless idle)
//            i_wr_en/idx/cur   input-current buffer write
//            i_cfg_we/thr/leak threshold and leak update (idle only)
//            o_busy            sweep in progress
//            o_done            one-cycle pulse at sweep end
//            o_spike_vec       spike flags of the last completed sweep
//            o_state_idx/out   neuron being updated and its new state
// Revision : 1.0  initial release
// ============================================================================
module neuron_scheduler #(
  parameter int NUM_NEURONS = neuron_pkg::NUM_NEURONS,
  parameter int STATE_W     = neuron_pkg::STATE_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_step,
  input  logic                          i_wr_en,
  input  logic [neuron_pkg::IDX_W-1:0]  i_wr_idx,
  input  logic [STATE_W-1:0]            i_wr_cur,
  input  logic                          i_cfg_we,
  input  logic [STATE_W-1:0]            i_cfg_thr,
  input  logic [1:0]                    i_cfg_leak,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [NUM_NEURONS-1:0]        o_spike_vec,
  output logic [neuron_pkg::IDX_W-1:0]  o_state_idx,
  output logic [STATE_W-1:0]            o_state_out
);

  import neuron_pkg::*;

  localparam logic [IDX_W:0]   c_NUM      = (IDX_W+1)'(NUM_NEURONS);
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  sched_state_t r_fsm;
  sched_state_t w_fsm_next;

  logic [IDX_W-1:0]       r_idx;
  logic [STATE_W-1:0]     r_thr;
  logic [1:0]             r_leak;
  logic [STATE_W-1:0]     r_mem [NUM_NEURONS];
  logic [STATE_W-1:0]     r_cur [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] r_spike;
  logic [NUM_NEURONS-1:0] r_spike_vec;

  logic                   w_busy;
  logic                   w_done;
  logic                   w_last;
  logic                   w_wr_ok;
  logic [STATE_W-1:0]     w_upd_state;
  logic                   w_upd_spike;
  logic [NUM_NEURONS-1:0] w_spike_merged;

  assign w_last  = (r_idx == c_LAST_IDX);
  assign w_wr_ok = i_wr_en && ({1'b0, i_wr_idx} < c_NUM);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (i_step) begin
          w_fsm_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_fsm_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done     = 1'b1;
        w_fsm_next = S_IDLE;
      end
      default: begin
        w_fsm_next = S_IDLE;
      end
    endcase
  end

  // Neuron pointer: walks 0..N-1 during UPDATE, parked at 0 otherwise so
  // the index output reads 0 outside a sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
    end else if (w_busy && !w_last) begin
      r_idx <= r_idx + IDX_W'(1);
    end else begin
      r_idx <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Configuration (only accepted while idle)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_thr  <= STATE_W'(THR_DEFAULT);
      r_leak <= 2'(LEAK_DEFAULT);
    end else if (i_cfg_we && (r_fsm == S_IDLE)) begin
      r_thr  <= i_cfg_thr;
      r_leak <= i_cfg_leak;
    end
  end

  // --------------------------------------------------------------------------
  // Shared datapath
  // --------------------------------------------------------------------------
  neuron_update #(
    .STATE_W (STATE_W)
  ) u_update (
    .i_state      (r_mem[r_idx]),
    .i_cur        (r_cur[r_idx]),
    .i_spike_prev (r_spike[r_idx]),
    .i_leak       (r_leak),
    .i_thr        (r_thr),
    .o_state      (w_upd_state),
    .o_spike      (w_upd_spike)
  );

  // --------------------------------------------------------------------------
  // Per-neuron storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_mem[i] <= '0;
        r_cur[i] <= '0;
      end
      r_spike <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (w_busy && (r_idx == IDX_W'(i))) begin
          r_mem[i]   <= w_upd_state;
          r_spike[i] <= w_upd_spike;
        end
        // A write landing on the neuron being consumed wins over the clear:
        // the datapath already read the old value this cycle, so the new
        // value is kept for the following sweep.
        if (w_wr_ok && (i_wr_idx == IDX_W'(i))) begin
          r_cur[i] <= i_wr_cur;
        end else if (w_busy && (r_idx == IDX_W'(i))) begin
          r_cur[i] <= '0;
        end
      end
    end
  end

  // Spike flags including the update happening this cycle, so the last
  // neuron's result is present when the vector is captured.
  always_comb begin
    w_spike_merged = r_spike;
    if (w_busy) begin
      w_spike_merged[r_idx] = w_upd_spike;
    end
  end

  // Captured on the final update edge so the vector is already valid in the
  // DONE cycle, alongside the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_spike_vec <= '0;
    end else if (w_busy && w_last) begin
      r_spike_vec <= w_spike_merged;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_busy      = w_busy;
  assign o_done      = w_done;
  assign o_spike_vec = r_spike_vec;
  assign o_state_idx = r_idx;
  assign o_state_out = w_busy ? w_upd_state : '0;

endmodule
`default_nettype wire

// File: tb/tb_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_scheduler
// Purpose  : Self-checking bench for neuron_scheduler. A behavioural model
//            predicts every per-neuron update and the spike vector when a
//            sweep is launched; a monitor pops and compares as the DUT
//            produces them.
// Revision : 1.0  initial release
// ============================================================================
module tb_neuron_scheduler;

  localparam int N  = 8;
  localparam int SW = 6;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_step = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [2:0]    i_wr_idx = '0;
  logic [SW-1:0] i_wr_cur = '0;
  logic          i_cfg_we = 1'b0;
  logic [SW-1:0] i_cfg_thr = '0;
  logic [1:0]    i_cfg_leak = '0;
  logic          o_busy;
  logic          o_done;
  logic [N-1:0]  o_spike_vec;
  logic [2:0]    o_state_idx;
  logic [SW-1:0] o_state_out;

  neuron_scheduler #(.NUM_NEURONS(N), .STATE_W(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_step      (i_step),
    .i_wr_en     (i_wr_en),
    .i_wr_idx    (i_wr_idx),
    .i_wr_cur    (i_wr_cur),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_thr   (i_cfg_thr),
    .i_cfg_leak  (i_cfg_leak),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_spike_vec (o_spike_vec),
    .o_state_idx (o_state_idx),
    .o_state_out (o_state_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  // Behavioural model
  int m_state [N];
  int m_cur   [N];
  bit m_spike [N];
  int m_thr;
  int m_leak;

  // Scoreboard
  int          q_idx [$];
  int          q_val [$];
  logic [N-1:0] q_vec [$];
  int          obs_state [N];

  function automatic int f_next(int st, int cu, bit sp, int lk);
    int keep;
    int s;
    keep = sp ? 0 : st / (1 << lk);
    s = cu + keep;
    if (s > SMAX) s = SMAX;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0;
      m_cur[i]   = 0;
      m_spike[i] = 1'b0;
    end
    m_thr  = 32;
    m_leak = 1;
  endtask

  // Monitor: compare each update and each done against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (o_busy) begin
        n_checks++;
        if (q_idx.size() == 0) begin
          n_fail++;
          $display("FAIL update_unexpected idx=%0d out=%0d (no update expected)", o_state_idx, o_state_out);
        end else begin
          int ei;
          int ev;
          ei = q_idx.pop_front();
          ev = q_val.pop_front();
          obs_state[o_state_idx] = int'(o_state_out);
          if (o_state_idx !== 3'(ei) || o_state_out !== SW'(ev)) begin
            n_fail++;
            $display("FAIL update idx=%0d out=%0d expected idx=%0d out=%0d", o_state_idx, o_state_out, ei, ev);
          end
        end
      end
      if (o_done) begin
        n_done++;
        n_checks++;
        if (q_vec.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected spike_vec=%h (no done expected)", o_spike_vec);
        end else begin
          logic [N-1:0] ev;
          ev = q_vec.pop_front();
          if (o_spike_vec !== ev) begin
            n_fail++;
            $display("FAIL spike_vec got=%h expected=%h", o_spike_vec, ev);
          end
        end
      end
    end
  end

  task automatic write_cur(input int idx, input int val);
    @(negedge clk);
    i_wr_en  = 1'b1;
    i_wr_idx = 3'(idx);
    i_wr_cur = SW'(val);
    @(negedge clk);
    i_wr_en  = 1'b0;
    m_cur[idx] = val;
  endtask

  task automatic write_cfg(input int thr, input int lk);
    @(negedge clk);
    i_cfg_we   = 1'b1;
    i_cfg_thr  = SW'(thr);
    i_cfg_leak = 2'(lk);
    @(negedge clk);
    i_cfg_we = 1'b0;
    m_thr  = thr;
    m_leak = lk;
  endtask

  // Launch a sweep and push its predicted results. Returns at the first
  // negedge of the sweep (neuron 0 on the outputs).
  task automatic start_step();
    logic [N-1:0] vec;
    @(negedge clk);
    i_step = 1'b1;
    for (int i = 0; i < N; i++) begin
      int ns;
      ns = f_next(m_state[i], m_cur[i], m_spike[i], m_leak);
      q_idx.push_back(i);
      q_val.push_back(ns);
      m_state[i] = ns;
      m_spike[i] = (ns >= m_thr);
      vec[i]     = m_spike[i];
      m_cur[i]   = 0;
    end
    q_vec.push_back(vec);
    @(negedge clk);
    i_step = 1'b0;
  endtask

  // Waits for the done pulse; returns cycles waited from neuron 0.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!o_done && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
    if (!o_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout waited=%0d cycles, required done", cycles);
    end
    @(negedge clk);
  endtask

  task automatic wait_idx(input int idx);
    int k;
    k = 0;
    while (!(o_busy && o_state_idx == 3'(idx)) && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (k >= 30) begin
      n_checks++;
      n_fail++;
      $display("FAIL idx_timeout idx=%0d not reached, required busy at idx", idx);
    end
  endtask

  task automatic sweep();
    int c;
    start_step();
    wait_done(c);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_busy, o_done, o_spike_vec, o_state_idx, o_state_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs busy=%b done=%b vec=%h idx=%0d out=%0d required all 0",
               o_busy, o_done, o_spike_vec, o_state_idx, o_state_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int c;
    write_cur(0, 40);
    start_step();
    wait_done(c);
    n_checks++;
    if (c != N) begin
      n_fail++;
      $display("FAIL done_latency got=%0d cycles after first update required=%0d", c, N);
    end
    n_checks++;
    if (obs_state[0] != 40 || o_spike_vec !== 8'h01) begin
      n_fail++;
      $display("FAIL basic state0=%0d vec=%h required 40 and 01", obs_state[0], o_spike_vec);
    end
  endtask

  task automatic test_saturation();
    write_cfg(63, 0);
    write_cur(3, 50);
    sweep();
    write_cur(3, 30);
    sweep();
    n_checks++;
    if (obs_state[3] != 63 || o_spike_vec[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL saturation state3=%0d spike=%b required 63 and 1", obs_state[3], o_spike_vec[3]);
    end
  endtask

  task automatic test_leak_refractory();
    write_cfg(63, 1);
    write_cur(5, 20);
    sweep();
    sweep();
    n_checks++;
    if (obs_state[5] != 10) begin
      n_fail++;
      $display("FAIL leak state5=%0d required 10", obs_state[5]);
    end
    write_cfg(32, 1);
    write_cur(6, 40);
    sweep();
    write_cur(6, 5);
    sweep();
    n_checks++;
    if (obs_state[6] != 5) begin
      n_fail++;
      $display("FAIL refractory state6=%0d required 5", obs_state[6]);
    end
  endtask

  task automatic test_collision();
    int c;
    write_cur(2, 3);
    start_step();
    wait_idx(2);
    i_wr_en  = 1'b1;
    i_wr_idx = 3'd2;
    i_wr_cur = SW'(7);
    @(negedge clk);
    i_wr_en = 1'b0;
    m_cur[2] = 7;
    wait_done(c);
    n_checks++;
    if (obs_state[2] != 3) begin
      n_fail++;
      $display("FAIL collision_this_sweep state2=%0d required 3", obs_state[2]);
    end
    sweep();
    n_checks++;
    if (obs_state[2] != 8) begin
      n_fail++;
      $display("FAIL collision_next_sweep state2=%0d required 8", obs_state[2]);
    end
  endtask

  task automatic test_threshold_zero();
    write_cfg(0, 1);
    sweep();
    n_checks++;
    if (o_spike_vec !== 8'hFF) begin
      n_fail++;
      $display("FAIL thr_zero vec=%h required ff", o_spike_vec);
    end
    write_cfg(32, 1);
  endtask

  task automatic test_busy_ignored();
    int d0;
    int c;
    write_cur(1, 33);
    d0 = n_done;
    start_step();
    @(negedge clk);
    i_step     = 1'b1;
    i_cfg_we   = 1'b1;
    i_cfg_thr  = '0;
    i_cfg_leak = 2'd3;
    @(negedge clk);
    i_step   = 1'b0;
    i_cfg_we = 1'b0;
    wait_idx(N - 1);
    @(negedge clk);
    // In the DONE cycle: another step and config attempt.
    i_step   = 1'b1;
    i_cfg_we = 1'b1;
    @(negedge clk);
    i_step   = 1'b0;
    i_cfg_we = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (n_done - d0 != 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignored done_pulses=%0d busy=%b required 1 and 0", n_done - d0, o_busy);
    end
    sweep();
    n_checks++;
    if (o_spike_vec !== 8'h00) begin
      n_fail++;
      $display("FAIL thr_unchanged vec=%h required 00", o_spike_vec);
    end
    // Back-to-back sweeps from the idle cycle right after done.
    write_cur(4, 36);
    start_step();
    wait_done(c);
    start_step();
    wait_done(c);
  endtask

  task automatic test_reset_abort();
    int d0;
    write_cfg(63, 2);
    write_cur(5, 50);
    write_cur(6, 50);
    d0 = n_done;
    start_step();
    wait_idx(4);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_busy, o_done, o_spike_vec, o_state_idx, o_state_out} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs busy=%b done=%b vec=%h idx=%0d out=%0d required all 0",
               o_busy, o_done, o_spike_vec, o_state_idx, o_state_out);
    end
    reset = 1'b0;
    q_idx.delete();
    q_val.delete();
    q_vec.delete();
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_done != d0) begin
      n_fail++;
      $display("FAIL abort_done done_pulses=%0d required 0", n_done - d0);
    end
    write_cur(7, 32);
    sweep();
    n_checks++;
    if (o_spike_vec !== 8'h80) begin
      n_fail++;
      $display("FAIL post_reset vec=%h required 80", o_spike_vec);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_leak_refractory();
    test_collision();
    test_threshold_zero();
    test_busy_ignored();
    test_reset_abort();
    repeat (2) @(negedge clk);
    n_checks++;
    if (q_idx.size() != 0 || q_vec.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover updates=%0d vectors=%0d required 0", q_idx.size(), q_vec.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
